// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared op encoding, step count and FSM states for the mul/div sequencer
package muldiv_ctrl_pkg;

    localparam int MulDivOpWD  = 4;
    localparam int OpDiv       = 3;
    localparam int OpDivu      = 2;
    localparam int OpMult      = 1;
    localparam int OpMultu     = 0;
    localparam int MulDivSteps = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_ZDIV = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic is_onehot4(input logic [MulDivOpWD-1:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_iter_core.sv
// rtl/muldiv_ctrl_iter_core.sv - 65-bit accumulator with one restoring-divide or shift-add step per cycle
// acc_o is the value the accumulator takes on the next step, so the last step's result is visible before it lands.
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   lo_init_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH:0]   acc_o
);

    logic [2*WIDTH:0]  acc_q;
    logic [WIDTH-1:0]  opnd_q;
    logic [WIDTH:0]    partial;
    logic [WIDTH+1:0]  diff;
    logic [WIDTH:0]    upper;

    always_comb begin
        partial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff    = {1'b0, partial} - {2'b00, opnd_q};
        upper   = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        if (is_div_i) begin
            // Partial remainder never exceeds 2*divisor, so a non-negative difference always fits WIDTH bits.
            if (!diff[WIDTH+1])
                acc_o = {1'b0, diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_o = {1'b0, partial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_o = {1'b0, upper, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else if (load_i) begin
            acc_q  <= {{(WIDTH+1){1'b0}}, lo_init_i};
            opnd_q <= opnd_i;
        end else if (step_i) begin
            acc_q  <= acc_o;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative div/divu/mult/multu sequencer with pipeline stall and one-cycle hi/lo write
// Optional MULDIV_FAST_MUL_EN: mult/multu finish in one cycle through a combinational multiplier.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = MulDivSteps
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MulDivOpWD-1:0] op,
    input  logic [WIDTH-1:0]      src_a,
    input  logic [WIDTH-1:0]      src_b,
    input  logic                  cancel,
    output logic                  stallreq_for_muldiv,
    output logic                  busy,
    output logic                  res_valid,
    output logic [WIDTH-1:0]      hi_o,
    output logic [WIDTH-1:0]      lo_o
);

    localparam int CW = $clog2(STEPS);

    md_state_e        state_q;
    logic [CW-1:0]    cnt_q;
    logic             is_div_q, neg_q, rem_neg_q, res_valid_q;
    logic [WIDTH-1:0] hi_q, lo_q, zdiv_a_q;

    logic             accept, op_div, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [2*WIDTH:0] acc;
    logic [WIDTH-1:0] div_hi, div_lo, fin_hi, fin_lo;
    logic [2*WIDTH-1:0] prod_s;
    logic             unused_acc_msb;

    assign op_div = op[OpDiv] | op[OpDivu];
    assign sa     = (op[OpDiv] | op[OpMult]) & src_a[WIDTH-1];
    assign sb     = (op[OpDiv] | op[OpMult]) & src_b[WIDTH-1];
    assign mag_a  = sa ? -src_a : src_a;
    assign mag_b  = sb ? -src_b : src_b;
    assign accept = (state_q == MD_IDLE) && start && !cancel && is_onehot4(op);

    assign stallreq_for_muldiv = accept || (state_q == MD_RUN) || (state_q == MD_ZDIV);
    assign busy      = (state_q != MD_IDLE);
    assign res_valid = res_valid_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept),
        .step_i    ((state_q == MD_RUN) && !cancel),
        .is_div_i  (is_div_q),
        .lo_init_i (op_div ? mag_a : mag_b),
        .opnd_i    (op_div ? mag_b : mag_a),
        .acc_o     (acc)
    );

    assign unused_acc_msb = acc[2*WIDTH];

    always_comb begin
        div_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        div_hi = rem_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        prod_s = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        fin_hi = is_div_q ? div_hi : prod_s[2*WIDTH-1:WIDTH];
        fin_lo = is_div_q ? div_lo : prod_s[WIDTH-1:0];
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fprod, fprod_s;
    assign fprod   = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
    assign fprod_s = (sa ^ sb) ? -fprod : fprod;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MD_IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            res_valid_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            zdiv_a_q    <= '0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (accept) begin
                        cnt_q     <= '0;
                        is_div_q  <= op_div;
                        neg_q     <= sa ^ sb;
                        rem_neg_q <= sa;
                        zdiv_a_q  <= src_a;
                        if (op_div && (src_b == '0))
                            state_q <= MD_ZDIV;
`ifdef MULDIV_FAST_MUL_EN
                        else if (!op_div) begin
                            state_q     <= MD_DONE;
                            res_valid_q <= 1'b1;
                            hi_q        <= fprod_s[2*WIDTH-1:WIDTH];
                            lo_q        <= fprod_s[WIDTH-1:0];
                        end
`endif
                        else
                            state_q <= MD_RUN;
                    end
                end
                MD_RUN: begin
                    if (cancel) begin
                        state_q <= MD_IDLE;
                    end else if (cnt_q == CW'(STEPS - 1)) begin
                        state_q     <= MD_DONE;
                        res_valid_q <= 1'b1;
                        hi_q        <= fin_hi;
                        lo_q        <= fin_lo;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                MD_ZDIV: begin
                    if (cancel) begin
                        state_q <= MD_IDLE;
                    end else begin
                        state_q     <= MD_DONE;
                        res_valid_q <= 1'b1;
                        hi_q        <= zdiv_a_q;
                        lo_q        <= '1;
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - randomized and directed checks of muldiv_ctrl against an arithmetic reference model
module tb_muldiv_ctrl;

    localparam logic [3:0] OP_DIV = 4'b1000, OP_DIVU = 4'b0100, OP_MULT = 4'b0010, OP_MULTU = 4'b0001;
`ifdef MULDIV_FAST_MUL_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = 33;
`endif

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, cancel = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] src_a = 32'd0, src_b = 32'd0;
    logic        stall, busy, res_valid;
    logic [31:0] hi_o, lo_o;

    int checks = 0, passes = 0;
    int cyc = 0;
    bit mon_en = 0;

    bit          m_active = 0;
    int          m_done = 0;
    logic [63:0] m_res = 64'd0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

    muldiv_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .op                  (op),
        .src_a               (src_a),
        .src_b               (src_b),
        .cancel              (cancel),
        .stallreq_for_muldiv (stall),
        .busy                (busy),
        .res_valid           (res_valid),
        .hi_o                (hi_o),
        .lo_o                (lo_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_res(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, p;
        logic [63:0] u;
        if ((o[3] || o[2]) && b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o[3]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        if (o[2]) return {a % b, a / b};
        if (o[1]) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return p;
        end
        u = {32'd0, a} * {32'd0, b};
        return u;
    endfunction

    function automatic int latency(input logic [3:0] o, input logic [31:0] b);
        if ((o[3] || o[2]) && b == 32'd0) return 2;
        if (o[1] || o[0]) return LAT_MUL;
        return 33;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0;
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else if (m_active) begin
            if (cyc == m_done) begin
                m_active = 0;
                m_hi = m_res[63:32];
                m_lo = m_res[31:0];
            end else if (cancel) begin
                m_active = 0;
            end
        end else if (start && !cancel && $countones(op) == 1) begin
            m_active = 1;
            m_res = model_res(op, src_a, src_b);
            m_done = cyc + latency(op, src_b);
        end
        cyc++;
        mon_en = 1;
    end

    always @(negedge clk) begin
        logic        e_stall, e_valid;
        logic [66:0] got, exp;
        if (mon_en) begin
            e_stall = m_active ? (cyc != m_done) : (start && !cancel && $countones(op) == 1);
            e_valid = m_active && (cyc == m_done);
            exp = {e_stall, m_active, e_valid, e_valid ? m_res : {m_hi, m_lo}};
            got = {stall, busy, res_valid, hi_o, lo_o};
            checks++;
            if (got === exp) passes++;
            else $display("FAIL model cyc=%0d {stall,busy,valid,hi,lo} got=%h want=%h", cyc, got, exp);
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%h want=%h", nm, got, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic exp_stall);
        start = 1'b1; op = o; src_a = a; src_b = b;
        #1 chk("stall_at_start", {63'd0, stall}, {63'd0, exp_stall});
        cycle();
        start = 1'b0; op = 4'd0;
    endtask

    task automatic lit_result(input string nm, input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        chk({nm, "_valid"}, {63'd0, res_valid}, 64'd1);
        chk({nm, "_hilo"}, {hi_o, lo_o}, {h, l});
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        cycle(); cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", {29'd0, stall, busy, res_valid, hi_o, lo_o}, 64'd0);
        cycle();

        issue(OP_DIVU, 32'd100, 32'd7, 1'b1);
        repeat (31) cycle();
        @(negedge clk) chk("divu_stall_c32", {63'd0, stall}, 64'd1);
        cycle();
        lit_result("divu_100_7", 32'd2, 32'd14);
        chk("divu_stall_c33", {63'd0, stall}, 64'd0);
        cycle();

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        repeat (32) cycle();
        lit_result("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        cycle();

        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1);
        repeat (LAT_MUL - 1) cycle();
        lit_result("mult_m1_2", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        cycle();

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
        repeat (LAT_MUL - 1) cycle();
        lit_result("multu_ff_2", 32'h1, 32'hFFFF_FFFE);
        cycle();

        issue(OP_DIV, 32'h1234, 32'd0, 1'b1);
        @(negedge clk) chk("zdiv_stall_c1", {63'd0, stall}, 64'd1);
        cycle();
        lit_result("zdiv", 32'h1234, 32'hFFFF_FFFF);
        chk("zdiv_stall_c2", {63'd0, stall}, 64'd0);
        cycle();

        issue(OP_DIVU, 32'd5000, 32'd3, 1'b1);
        repeat (9) cycle();
        cancel = 1'b1;
        cycle();
        cancel = 1'b0;
        @(negedge clk);
        chk("cancel_busy_valid", {62'd0, busy, res_valid}, 64'd0);
        chk("cancel_hilo_kept", {hi_o, lo_o}, {32'h1234, 32'hFFFF_FFFF});
        cycle();
        issue(OP_DIVU, 32'd1000, 32'd10, 1'b1);
        repeat (32) cycle();
        lit_result("after_cancel", 32'd0, 32'd100);
        cycle();

        issue(OP_MULTU, 32'd12345, 32'd678, 1'b1);
        repeat (19) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_mid_op", {29'd0, stall, busy, res_valid, hi_o, lo_o}, 64'd0);
        cycle();

        issue(4'b0011, 32'd9, 32'd9, 1'b0);
        @(negedge clk) chk("bad_op_idle", {62'd0, busy, stall}, 64'd0);
        cycle();

        for (int i = 0; i < 4000; i++) begin
            if (!start || $urandom_range(0, 3) == 0) begin
                start = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 9))
                    0: op = 4'($urandom);
                    1, 2: op = OP_DIV;
                    3, 4: op = OP_DIVU;
                    5, 6: op = OP_MULT;
                    default: op = OP_MULTU;
                endcase
                src_a = rnd_operand();
                src_b = rnd_operand();
            end
            cancel = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 499) == 0);
            cycle();
        end
        start = 1'b0; cancel = 1'b0; rst = 1'b0;
        repeat (40) cycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
